// File: rtl/mips_pkg.sv
// mips_pkg: shared load/writeback encodings, W-stage register layout and reset PC
package mips_pkg;
  typedef enum logic [2:0] {LD_NONE = 3'd0, LW = 3'd1, LB = 3'd2, LBU = 3'd3, LH = 3'd4, LHU = 3'd5} ld_op_t;
  typedef enum logic [1:0] {WB_ALU = 2'd0, WB_MEM = 2'd1, WB_LINK = 2'd2, WB_RSVD = 2'd3} wb_sel_t;
  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] dr;
    ld_op_t      ld_op;
    wb_sel_t     wb_sel;
    logic [4:0]  rd;
    logic        reg_we;
  } w_regs_t;
endpackage

// File: rtl/load_extend.sv
// load_extend: byte/halfword lane select with sign/zero extension and misalignment detect
// ports: dr (aligned memory word), off (byte offset), ld_op (load kind) -> data, misaligned
module load_extend
  import mips_pkg::*;
(
  input  logic [31:0] dr,
  input  logic [1:0]  off,
  input  ld_op_t      ld_op,
  output logic [31:0] data,
  output logic        misaligned
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = dr[{off, 3'b000} +: 8];
    h = off[1] ? dr[31:16] : dr[15:0];
    data = (ld_op == LB)  ? {{24{b[7]}}, b} :
           (ld_op == LBU) ? {24'b0, b} :
           (ld_op == LH)  ? {{16{h[15]}}, h} :
           (ld_op == LHU) ? {16'b0, h} : dr;
    misaligned = ((ld_op == LW) && (off != 2'b00)) || (((ld_op == LH) || (ld_op == LHU)) && off[0]);
  end
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM->WB pipeline register plus writeback mux, GRF write port and W forwarding bus
// in : clk, reset (sync high), stall, flush, m_valid/m_pc/m_alu/m_dr/m_ld_op/m_wb_sel/m_rd/m_reg_we
// out: w_valid, w_pc, w_rd, w_reg_we, w_wdata, w_adel, w_badaddr
// WB_TRACE_EN: when defined, prints each GRF write in simulation
module mem_wb_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        m_valid,
  input  logic [31:0] m_pc,
  input  logic [31:0] m_alu,
  input  logic [31:0] m_dr,
  input  logic [2:0]  m_ld_op,
  input  logic [1:0]  m_wb_sel,
  input  logic [4:0]  m_rd,
  input  logic        m_reg_we,
  output logic        w_valid,
  output logic [31:0] w_pc,
  output logic [4:0]  w_rd,
  output logic        w_reg_we,
  output logic [31:0] w_wdata,
  output logic        w_adel,
  output logic [31:0] w_badaddr
);
  localparam w_regs_t W_BUBBLE = '{valid: 1'b0, pc: PC_RESET, alu: 32'h0, dr: 32'h0,
                                   ld_op: LD_NONE, wb_sel: WB_ALU, rd: 5'd0, reg_we: 1'b0};
  w_regs_t     w_d, w_q;
  logic [31:0] ld_data;
  logic        ld_mis;
  always_comb begin
    w_d = flush ? W_BUBBLE :
          stall ? w_q :
          '{valid: m_valid, pc: m_pc, alu: m_alu, dr: m_dr, ld_op: ld_op_t'(m_ld_op),
            wb_sel: wb_sel_t'(m_wb_sel), rd: m_rd, reg_we: m_reg_we};
  end
  always_ff @(posedge clk) begin
    if (reset) w_q <= W_BUBBLE;
    else       w_q <= w_d;
  end
  load_extend u_load_extend (
    .dr        (w_q.dr),
    .off       (w_q.alu[1:0]),
    .ld_op     (w_q.ld_op),
    .data      (ld_data),
    .misaligned(ld_mis)
  );
  always_comb begin
    w_valid   = w_q.valid;
    w_pc      = w_q.pc;
    w_rd      = w_q.rd;
    w_adel    = ld_mis;
    w_badaddr = ld_mis ? w_q.alu : 32'h0;
    w_wdata   = (w_q.wb_sel == WB_ALU)  ? w_q.alu :
                (w_q.wb_sel == WB_MEM)  ? ld_data :
                (w_q.wb_sel == WB_LINK) ? w_q.pc + 32'd8 : 32'h0;
    w_reg_we  = w_q.valid & w_q.reg_we & (w_q.rd != 5'd0) & ~ld_mis;
  end
`ifdef WB_TRACE_EN
  always @(posedge clk) begin
    if (!reset && w_reg_we) $display("%d@%h: $%d <= %h", $time, w_pc, w_rd, w_wdata);
  end
`else
`endif
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: vector table through a scoreboard, plus stall/flush sequences
module tb_mem_wb_stage;
  import mips_pkg::*;
  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic        m_valid, m_reg_we;
  logic [31:0] m_pc, m_alu, m_dr;
  logic [2:0]  m_ld_op;
  logic [1:0]  m_wb_sel;
  logic [4:0]  m_rd;
  logic        w_valid, w_reg_we, w_adel;
  logic [31:0] w_pc, w_wdata, w_badaddr;
  logic [4:0]  w_rd;
  int n_checks = 0;
  int n_fail = 0;
  typedef struct {
    logic v; logic [31:0] pc, alu, dr; logic [2:0] ld; logic [1:0] sel; logic [4:0] rd; logic we;
    logic [31:0] wdata; logic rwe; logic adel; logic [31:0] bad;
  } vec_t;
  typedef struct {
    logic v; logic [31:0] pc; logic [4:0] rd; logic [31:0] wdata; logic we, adel; logic [31:0] bad;
  } exp_t;
  exp_t sb[$];
  vec_t vecs[16];
  mem_wb_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .m_valid(m_valid), .m_pc(m_pc), .m_alu(m_alu), .m_dr(m_dr), .m_ld_op(m_ld_op),
    .m_wb_sel(m_wb_sel), .m_rd(m_rd), .m_reg_we(m_reg_we),
    .w_valid(w_valid), .w_pc(w_pc), .w_rd(w_rd), .w_reg_we(w_reg_we),
    .w_wdata(w_wdata), .w_adel(w_adel), .w_badaddr(w_badaddr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input vec_t x, input bit push);
    m_valid = x.v; m_pc = x.pc; m_alu = x.alu; m_dr = x.dr; m_ld_op = x.ld;
    m_wb_sel = x.sel; m_rd = x.rd; m_reg_we = x.we;
    if (push) sb.push_back('{x.v, x.pc, x.rd, x.wdata, x.rwe, x.adel, x.bad});
  endtask
  task automatic check_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, " scoreboard empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    chk({tag, " w_valid"},   {31'b0, w_valid},  {31'b0, e.v});
    chk({tag, " w_pc"},      w_pc,              e.pc);
    chk({tag, " w_rd"},      {27'b0, w_rd},     {27'b0, e.rd});
    chk({tag, " w_wdata"},   w_wdata,           e.wdata);
    chk({tag, " w_reg_we"},  {31'b0, w_reg_we}, {31'b0, e.we});
    chk({tag, " w_adel"},    {31'b0, w_adel},   {31'b0, e.adel});
    chk({tag, " w_badaddr"}, w_badaddr,         e.bad);
  endtask
  task automatic check_bubble(input string tag);
    chk({tag, " w_valid"},   {31'b0, w_valid},  32'd0);
    chk({tag, " w_pc"},      w_pc,              32'h0000_3000);
    chk({tag, " w_reg_we"},  {31'b0, w_reg_we}, 32'd0);
    chk({tag, " w_wdata"},   w_wdata,           32'h0);
    chk({tag, " w_adel"},    {31'b0, w_adel},   32'd0);
    chk({tag, " w_badaddr"}, w_badaddr,         32'h0);
  endtask
  initial begin
    //           v  pc            alu           dr            ld       sel      rd     we   wdata         rwe  adel bad
    vecs[0]  = '{1, 32'h3000, 32'h0000_0013, 32'h80FF_7F01, LB,      WB_MEM,  5'd8,  1, 32'hFFFF_FF80, 1, 0, 32'h0};
    vecs[1]  = '{1, 32'h3004, 32'h0000_0012, 32'h80FF_7F01, LHU,     WB_MEM,  5'd9,  1, 32'h0000_80FF, 1, 0, 32'h0};
    vecs[2]  = '{1, 32'h3008, 32'h0000_0012, 32'h80FF_7F01, LH,      WB_MEM,  5'd10, 1, 32'hFFFF_80FF, 1, 0, 32'h0};
    vecs[3]  = '{1, 32'h300C, 32'h0000_0010, 32'h80FF_7F01, LH,      WB_MEM,  5'd11, 1, 32'h0000_7F01, 1, 0, 32'h0};
    vecs[4]  = '{1, 32'h3010, 32'h0000_0011, 32'h80FF_7F01, LBU,     WB_MEM,  5'd12, 1, 32'h0000_007F, 1, 0, 32'h0};
    vecs[5]  = '{1, 32'h3014, 32'h0000_0012, 32'h80FF_7F01, LBU,     WB_MEM,  5'd13, 1, 32'h0000_00FF, 1, 0, 32'h0};
    vecs[6]  = '{1, 32'h3018, 32'h0000_0006, 32'h1234_5678, LW,      WB_MEM,  5'd14, 1, 32'h1234_5678, 0, 1, 32'h6};
    vecs[7]  = '{1, 32'h301C, 32'h0000_0005, 32'h80FF_7F01, LH,      WB_MEM,  5'd15, 1, 32'h0000_7F01, 0, 1, 32'h5};
    vecs[8]  = '{1, 32'h3020, 32'h0000_0008, 32'hDEAD_BEEF, LW,      WB_MEM,  5'd16, 1, 32'hDEAD_BEEF, 1, 0, 32'h0};
    vecs[9]  = '{1, 32'h3010, 32'h0000_0000, 32'h0,         LD_NONE, WB_LINK, 5'd31, 1, 32'h0000_3018, 1, 0, 32'h0};
    vecs[10] = '{1, 32'hFFFF_FFFC, 32'h0,    32'h0,         LD_NONE, WB_LINK, 5'd31, 1, 32'h0000_0004, 1, 0, 32'h0};
    vecs[11] = '{1, 32'h3024, 32'h0000_1234, 32'h0,         LD_NONE, WB_ALU,  5'd0,  1, 32'h0000_1234, 0, 0, 32'h0};
    vecs[12] = '{1, 32'h3028, 32'hAAAA_5555, 32'h1111_2222, LD_NONE, WB_RSVD, 5'd5,  1, 32'h0,         1, 0, 32'h0};
    vecs[13] = '{0, 32'h302C, 32'h0000_0777, 32'h0,         LD_NONE, WB_ALU,  5'd3,  1, 32'h0000_0777, 0, 0, 32'h0};
    vecs[14] = '{1, 32'h3030, 32'h0000_0003, 32'h80FF_7F01, LHU,     WB_MEM,  5'd7,  1, 32'h0000_80FF, 0, 1, 32'h3};
    vecs[15] = '{1, 32'h3034, 32'h0000_0021, 32'hCAFE_F00D, LD_NONE, WB_MEM,  5'd6,  0, 32'hCAFE_F00D, 0, 0, 32'h0};
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(vecs[8], 1'b0);
    step();
    step();
    check_bubble("reset");
    reset = 1'b0;
    foreach (vecs[i]) begin
      drive(vecs[i], 1'b1);
      step();
      check_out($sformatf("vec%0d", i));
    end
    drive(vecs[0], 1'b1);
    step();
    check_out("stall capture A");
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      drive(vecs[8 + c], 1'b0);
      step();
      chk($sformatf("stall%0d w_wdata", c), w_wdata, 32'hFFFF_FF80);
      chk($sformatf("stall%0d w_pc", c), w_pc, 32'h0000_3000);
      chk($sformatf("stall%0d w_rd", c), {27'b0, w_rd}, 32'd8);
      chk($sformatf("stall%0d w_reg_we", c), {31'b0, w_reg_we}, 32'd1);
    end
    flush = 1'b1;
    step();
    check_bubble("flush+stall");
    stall = 1'b0;
    drive(vecs[8], 1'b0);
    step();
    check_bubble("flush only");
    flush = 1'b0;
    drive(vecs[9], 1'b1);
    step();
    check_out("resume after flush");
    drive(vecs[8], 1'b0);
    reset = 1'b1; flush = 1'b0;
    step();
    check_bubble("reset beats capture");
    reset = 1'b0;
    chk("scoreboard drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
